// File: rtl/alarm_game_pkg.sv
// Shared types and constants for the alarm dismissal mini-game.
package alarm_game_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RING,
      ARM,
      SHOW,
      DONE
   } state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int unsigned ROUND_W = 4;
   localparam int unsigned SEC_W   = 6;
   localparam int unsigned FAIL_W  = 8;

   // Fibonacci step: taps 16,14,13,11 map to bits 15,13,12,10, shifting toward the MSB.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/alarm_dismiss_game_if.sv
// Game control/status bundle between the alarm logic and the dismissal game.
interface alarm_dismiss_game_if #(
   parameter int unsigned NUM_SW = 10
);
   import alarm_game_pkg::*;

   logic                 alarm_trig;
   logic                 alarm_en;
   logic                 start;
   logic [NUM_SW-1:0]    sw;
   logic                 ringing;
   logic [NUM_SW-1:0]    target_led;
   logic [ROUND_W-1:0]   round_idx;
   logic [SEC_W-1:0]     sec_left;
   logic                 dismissed;
   logic [FAIL_W-1:0]    fail_cnt;

   modport master (
      output alarm_trig, alarm_en, start, sw,
      input  ringing, target_led, round_idx, sec_left, dismissed, fail_cnt
   );

   modport slave (
      input  alarm_trig, alarm_en, start, sw,
      output ringing, target_led, round_idx, sec_left, dismissed, fail_cnt
   );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick game targets.
module lfsr16
   import alarm_game_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_osc,
   input  logic        rst,
   output logic [15:0] state
);

   always_ff @(posedge clk_osc) begin
      if (rst) state <= SEED;
      else     state <= lfsr_step(state);
   end

endmodule

// File: rtl/alarm_dismiss_game.sv
// Alarm dismissal game: keeps the alarm ringing until ROUNDS random switch targets
// are hit in a row, each within TIMEOUT_SEC seconds.
module alarm_dismiss_game
   import alarm_game_pkg::*;
#(
   parameter int unsigned NUM_SW        = 10,
   parameter int unsigned ROUNDS        = 3,
   parameter int unsigned TICKS_PER_SEC = 1000,
   parameter int unsigned TIMEOUT_SEC   = 5,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                clk_osc,
   input  logic                rst,
   alarm_dismiss_game_if.slave bus
);

   localparam int unsigned TGT_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
   localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   state_e             state, state_nxt;
   logic [15:0]        lfsr;
   logic               start_q;
   logic [PRE_W-1:0]   pre_cnt, pre_nxt;
   logic [TGT_W-1:0]   tgt, tgt_nxt, pick;
   logic               tgt_vld, tgt_vld_nxt;
   logic [ROUND_W-1:0] round_q, round_nxt;
   logic [SEC_W-1:0]   sec_q, sec_nxt;
   logic [FAIL_W-1:0]  fail_q, fail_nxt;
   logic               ringing_q, ringing_nxt;
   logic [NUM_SW-1:0]  led_q, led_nxt;
   logic               dismissed_q, dismissed_nxt;
   logic [15:0]        cand;
   logic [NUM_SW-1:0]  tgt_oh;
   logic               start_rise, wrap, timeout;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk_osc (clk_osc),
      .rst     (rst),
      .state   (lfsr)
   );

   assign start_rise = bus.start & ~start_q;
   assign tgt_oh     = NUM_SW'(1) << tgt;
   assign wrap       = (pre_cnt == PRE_W'(TICKS_PER_SEC - 1));
   assign timeout    = wrap && (sec_q <= SEC_W'(1));

   // Next target: LFSR modulo switch count, bumped by one if it repeats the last target.
   always_comb begin
      cand = lfsr % 16'(NUM_SW);
      if (tgt_vld && (cand == 16'(tgt))) cand = (cand + 16'd1) % 16'(NUM_SW);
      pick = TGT_W'(cand);
   end

   always_comb begin
      state_nxt     = state;
      pre_nxt       = pre_cnt;
      tgt_nxt       = tgt;
      tgt_vld_nxt   = tgt_vld;
      round_nxt     = round_q;
      sec_nxt       = sec_q;
      fail_nxt      = fail_q;
      dismissed_nxt = 1'b0;
      ringing_nxt   = 1'b0;
      led_nxt       = '0;

      case (state)
         IDLE: begin
            round_nxt = '0;
            sec_nxt   = '0;
            if (bus.alarm_trig) state_nxt = RING;
         end
         RING: begin
            round_nxt = '0;
            if (start_rise) state_nxt = ARM;
         end
         ARM: begin
            if (bus.sw == '0) begin
               tgt_nxt     = pick;
               tgt_vld_nxt = 1'b1;
               sec_nxt     = SEC_W'(TIMEOUT_SEC);
               pre_nxt     = '0;
               state_nxt   = SHOW;
            end
         end
         SHOW: begin
            pre_nxt = wrap ? '0 : pre_cnt + PRE_W'(1);
            if (wrap) sec_nxt = sec_q - SEC_W'(1);
            // Correct match wins over a wrong switch, which wins over timeout.
            if (bus.sw == tgt_oh) begin
               round_nxt = round_q + ROUND_W'(1);
               state_nxt = (round_nxt == ROUND_W'(ROUNDS)) ? DONE : ARM;
            end else if ((bus.sw != '0) || timeout) begin
               if (fail_q != '1) fail_nxt = fail_q + FAIL_W'(1);
               round_nxt = '0;
               sec_nxt   = '0;
               state_nxt = RING;
            end
         end
         DONE: begin
            dismissed_nxt = 1'b1;
            round_nxt     = '0;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Turning the alarm off abandons the game silently from any state.
      if (!bus.alarm_en) begin
         state_nxt     = IDLE;
         tgt_nxt       = tgt;
         tgt_vld_nxt   = tgt_vld;
         round_nxt     = '0;
         sec_nxt       = '0;
         dismissed_nxt = 1'b0;
      end

      ringing_nxt = (state_nxt == RING) || (state_nxt == ARM) || (state_nxt == SHOW);
      led_nxt     = (state_nxt == SHOW) ? (NUM_SW'(1) << tgt_nxt) : '0;
   end

   always_ff @(posedge clk_osc) begin
      if (rst) begin
         state       <= IDLE;
         start_q     <= 1'b0;
         pre_cnt     <= '0;
         tgt         <= '0;
         tgt_vld     <= 1'b0;
         round_q     <= '0;
         sec_q       <= '0;
         fail_q      <= '0;
         ringing_q   <= 1'b0;
         led_q       <= '0;
         dismissed_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         start_q     <= bus.start;
         pre_cnt     <= pre_nxt;
         tgt         <= tgt_nxt;
         tgt_vld     <= tgt_vld_nxt;
         round_q     <= round_nxt;
         sec_q       <= sec_nxt;
         fail_q      <= fail_nxt;
         ringing_q   <= ringing_nxt;
         led_q       <= led_nxt;
         dismissed_q <= dismissed_nxt;
      end
   end

   assign bus.ringing    = ringing_q;
   assign bus.target_led = led_q;
   assign bus.round_idx  = round_q;
   assign bus.sec_left   = sec_q;
   assign bus.dismissed  = dismissed_q;
   assign bus.fail_cnt   = fail_q;

endmodule

// File: tb/tb_alarm_dismiss_game.sv
// Directed-plus-random bench for alarm_dismiss_game with its own LFSR/target model.
module tb_alarm_dismiss_game;

   localparam int unsigned NSW  = 4;
   localparam int unsigned NRND = 2;
   localparam int unsigned TPS  = 10;
   localparam int unsigned TOS  = 3;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk_osc = 1'b0;
   logic rst;

   always #5 clk_osc = ~clk_osc;

   alarm_dismiss_game_if #(.NUM_SW(NSW)) bus ();

   alarm_dismiss_game #(
      .NUM_SW        (NSW),
      .ROUNDS        (NRND),
      .TICKS_PER_SEC (TPS),
      .TIMEOUT_SEC   (TOS),
      .LFSR_SEED     (SEED)
   ) dut (
      .clk_osc (clk_osc),
      .rst     (rst),
      .bus     (bus)
   );

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned fails  = 0;

   logic [15:0] m_lfsr;
   int          prev_t;
   bit          prev_vld;
   int          cur_t;
   int          exp_fail;

   function automatic logic [15:0] model_next(input logic [15:0] s);
      int fb;
      fb = int'(s[15]) ^ int'(s[13]) ^ int'(s[12]) ^ int'(s[10]);
      return 16'(((int'(s) * 2) + fb) % 65536);
   endfunction

   function automatic logic [31:0] oh(input int i);
      logic [31:0] one;
      one = 32'd1;
      return one << i;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_osc);
      m_lfsr = rst ? SEED : model_next(m_lfsr);
      #1;
   endtask

   task automatic idle_random();
      int n;
      n = int'($urandom_range(0, 9));
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ringing"}, 32'(bus.ringing), 32'd0);
      check({tag, "_led"},     32'(bus.target_led), 32'd0);
      check({tag, "_round"},   32'(bus.round_idx), 32'd0);
      check({tag, "_sec"},     32'(bus.sec_left), 32'd0);
      check({tag, "_dism"},    32'(bus.dismissed), 32'd0);
      check({tag, "_fail"},    32'(bus.fail_cnt), 32'd0);
   endtask

   // Called in an ARM cycle: release all switches so the target latches on this edge.
   task automatic latch_and_check();
      logic [15:0] a;
      int t;
      bus.sw = '0;
      a = m_lfsr;
      step();
      t = int'(a) % NSW;
      if (prev_vld && t == prev_t) t = (t + 1) % NSW;
      if (prev_vld) check("tgt_not_repeat", 32'(bus.target_led) & oh(prev_t), 32'd0);
      check("target_led", 32'(bus.target_led), oh(t));
      check("sec_load", 32'(bus.sec_left), 32'(TOS));
      prev_t   = t;
      prev_vld = 1'b1;
      cur_t    = t;
   endtask

   task automatic trigger();
      check("idle_ringing", 32'(bus.ringing), 32'd0);
      bus.alarm_trig = 1'b1;
      step();
      bus.alarm_trig = 1'b0;
      check("trig_ringing", 32'(bus.ringing), 32'd1);
   endtask

   // Called in a RING cycle with start low.
   task automatic enter_show();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      latch_and_check();
   endtask

   // Called in a RING cycle: wins every round and checks the dismissal pulse.
   task automatic play_win();
      int pulses;
      enter_show();
      for (int r = 0; r < int'(NRND); r++) begin
         bus.sw = 4'(oh(cur_t));
         step();
         check("round_inc", 32'(bus.round_idx), 32'(r + 1));
         if (r < int'(NRND) - 1) begin
            check("arm_ringing", 32'(bus.ringing), 32'd1);
            check("arm_led", 32'(bus.target_led), 32'd0);
            latch_and_check();
         end
      end
      check("done_ringing", 32'(bus.ringing), 32'd0);
      check("done_led", 32'(bus.target_led), 32'd0);
      check("done_dism_early", 32'(bus.dismissed), 32'd0);
      bus.sw = '0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 0) check("dismissed", 32'(bus.dismissed), 32'd1);
         if (bus.dismissed) pulses++;
      end
      check("dism_pulses", 32'(pulses), 32'd1);
      check("post_round", 32'(bus.round_idx), 32'd0);
      check("post_fail", 32'(bus.fail_cnt), 32'(exp_fail));
   endtask

   task automatic expect_mistake(input string tag);
      exp_fail = (exp_fail < 255) ? exp_fail + 1 : 255;
      check({tag, "_ringing"}, 32'(bus.ringing), 32'd1);
      check({tag, "_led"},     32'(bus.target_led), 32'd0);
      check({tag, "_round"},   32'(bus.round_idx), 32'd0);
      check({tag, "_fail"},    32'(bus.fail_cnt), 32'(exp_fail));
   endtask

   initial begin
      int wrong;
      rst            = 1'b1;
      bus.alarm_trig = 1'b0;
      bus.alarm_en   = 1'b1;
      bus.start      = 1'b0;
      bus.sw         = '0;
      prev_vld       = 1'b0;
      prev_t         = 0;
      cur_t          = 0;
      exp_fail       = 0;
      step();
      step();
      check_reset_vals("reset");
      rst = 1'b0;

      // Nominal dismissal.
      idle_random();
      trigger();
      play_win();

      // Wrong single switch, then a clean win.
      idle_random();
      trigger();
      enter_show();
      wrong = (cur_t + int'($urandom_range(1, NSW - 1))) % NSW;
      bus.sw = 4'(oh(wrong));
      step();
      expect_mistake("wrong_sw");
      bus.sw = '0;
      step();
      play_win();

      // Timeout: three seconds of TPS cycles each, then back to RING.
      idle_random();
      trigger();
      enter_show();
      for (int i = 0; i < int'(TPS * TOS); i++) begin
         check("sec_count", 32'(bus.sec_left), 32'(int'(TOS) - i / int'(TPS)));
         check("tmo_led", 32'(bus.target_led), oh(cur_t));
         step();
      end
      expect_mistake("timeout");
      check("tmo_sec", 32'(bus.sec_left), 32'd0);

      // alarm_trig in SHOW is ignored; two switches up including the target is a mistake.
      enter_show();
      bus.alarm_trig = 1'b1;
      step();
      bus.alarm_trig = 1'b0;
      check("trig_show_led", 32'(bus.target_led), oh(cur_t));
      check("trig_show_ring", 32'(bus.ringing), 32'd1);
      check("trig_show_sec", 32'(bus.sec_left), 32'(TOS));
      bus.sw = 4'(oh(cur_t) | oh((cur_t + 1) % NSW));
      step();
      expect_mistake("two_sw");
      bus.sw = '0;
      step();
      play_win();

      // Twenty rounds over ten dismissals with random phase.
      for (int g = 0; g < 10; g++) begin
         idle_random();
         trigger();
         play_win();
      end

      // Disable mid-game after one completed round.
      trigger();
      enter_show();
      bus.sw = 4'(oh(cur_t));
      step();
      latch_and_check();
      bus.alarm_en = 1'b0;
      step();
      check("dis_ringing", 32'(bus.ringing), 32'd0);
      check("dis_led", 32'(bus.target_led), 32'd0);
      check("dis_round", 32'(bus.round_idx), 32'd0);
      check("dis_sec", 32'(bus.sec_left), 32'd0);
      check("dis_fail", 32'(bus.fail_cnt), 32'(exp_fail));
      for (int i = 0; i < 3; i++) begin
         check("dis_no_dism", 32'(bus.dismissed), 32'd0);
         step();
      end
      bus.alarm_en = 1'b1;
      step();

      // Reset while waiting in ARM.
      trigger();
      bus.sw    = 4'b0001;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      check("arm_wait_ring", 32'(bus.ringing), 32'd1);
      check("arm_wait_led", 32'(bus.target_led), 32'd0);
      rst = 1'b1;
      step();
      rst      = 1'b0;
      bus.sw   = '0;
      prev_vld = 1'b0;
      exp_fail = 0;
      check_reset_vals("rst_arm");

      // Saturation of the mistake counter.
      trigger();
      for (int k = 0; k < 260; k++) begin
         enter_show();
         bus.sw = 4'hF;
         step();
         exp_fail = (exp_fail < 255) ? exp_fail + 1 : 255;
         check("sat_fail", 32'(bus.fail_cnt), 32'(exp_fail));
         bus.sw = '0;
      end
      check("sat_final", 32'(bus.fail_cnt), 32'd255);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alarm_dismiss_game.md
Name: alarm_dismiss_game

Overview:
- Parametrised alarm-dismissal mini-game for the digital clock.
- Starts when the alarm fires with alarm-enable set. Keeps ringing until the user flips a pseudo-randomly chosen slide switch in each of ROUNDS consecutive rounds, with no mistakes.
- Generalises the fixed single-switch dismissal: switch count, round count, per-round timeout and target sequence are all configurable.
- Sits between the alarm comparator and the LED/buzzer outputs in Main.

Parameters:
- NUM_SW, 10, number of game switches (2..16).
- ROUNDS, 3, correct rounds required to dismiss (1..15).
- TICKS_PER_SEC, 1000, clk_osc cycles per one second of game time.
- TIMEOUT_SEC, 5, seconds allowed per round (1..63).
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
- clk_osc  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alarm_trig  in  1  one-cycle pulse when the clock time equals the alarm time.
- alarm_en  in  1  alarm on/off switch level.
- start  in  1  debounced middle push-button level; rising edge detected internally.
- sw  in  NUM_SW  debounced game switch levels.
- ringing  out  1  alarm sound/LED request.
- target_led  out  NUM_SW  one-hot target indicator; 0 when no round is active.
- round_idx  out  4  rounds completed in the current attempt.
- sec_left  out  6  seconds remaining in the current round.
- dismissed  out  1  one-cycle pulse on successful dismissal.
- fail_cnt  out  8  mistakes since reset; saturates at 255.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high on rst, sampled at the rising edge of clk_osc.
- Reset values: state=IDLE, ringing=0, target_led=0, round_idx=0, sec_left=0, dismissed=0, fail_cnt=0, LFSR=LFSR_SEED, start edge register=0.
- Reset takes effect mid-game: the next state is IDLE with all outputs at reset values.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, advances every cycle including IDLE.
  - Candidate target t = lfsr % NUM_SW.
  - If t equals the previous round's target, use (t+1) % NUM_SW.
- Global rule: alarm_en=0 in any state forces IDLE next cycle. No dismissed pulse; round_idx, target_led and sec_left clear; fail_cnt keeps its value.
- IDLE:
  - ringing=0.
  - alarm_trig & alarm_en -> RING.
  - alarm_trig outside IDLE is ignored.
- RING:
  - ringing=1, target_led=0, round_idx=0.
  - Rising edge of start -> ARM.
- ARM:
  - ringing=1, target_led=0.
  - Waits until sw == 0.
  - On that cycle: latch the target, load sec_left=TIMEOUT_SEC, clear the prescaler -> SHOW.
  - target_led shows the one-hot target from the first SHOW cycle.
- SHOW (ringing=1):
  - Prescaler counts 0..TICKS_PER_SEC-1. At wrap, sec_left decrements.
  - sw == one-hot target: round_idx+1. If the new value == ROUNDS -> DONE, else -> ARM.
  - sw != 0 and sw != target (including multiple switches up): mistake.
  - sec_left reaches 0 at a prescaler wrap: timeout, same handling as a mistake.
  - Mistake handling: fail_cnt+1 (saturating), round_idx=0, target_led=0 -> RING. The user must press start again.
  - Priority within a cycle: correct match > wrong switch > timeout.
- DONE:
  - dismissed=1 for exactly this cycle, ringing=0, target_led=0 -> IDLE.
  - round_idx clears in IDLE.
- Latency:
  - alarm_trig to ringing=1: 1 cycle.
  - Correct switch to dismissed (final round): 2 cycles.

Decomposition:
- Shared package alarm_game_pkg: state enum (IDLE, RING, ARM, SHOW, DONE), LFSR tap mask 16'hB400, width constants for round_idx/sec_left/fail_cnt.
- One sub-module: lfsr16 (clk_osc, rst, seed parameter, 16-bit state out).
- Prescaler, timeout counter and FSM stay in alarm_dismiss_game.

Test Plan:
(bench parameters NUM_SW=4, ROUNDS=2, TICKS_PER_SEC=10, TIMEOUT_SEC=3; the bench carries its own LFSR model)
- Nominal dismissal: alarm_en=1, alarm_trig pulse -> ringing=1 next cycle. start edge, sw=0 -> target_led = model target. Set matching sw, then sw=0, then the second target -> dismissed pulses once, ringing=0, fail_cnt=0.
- Wrong switch: in SHOW set a non-target bit -> state RING, fail_cnt=1, round_idx=0, target_led=0. Then complete both rounds -> dismissed.
- Timeout: enter SHOW and hold sw=0 for 30 cycles -> sec_left goes 3,2,1 and then timeout; fail_cnt+1, back in RING.
- Simultaneous/edge cases:
  - alarm_trig while in SHOW -> no change.
  - Two switches up, including the target -> mistake.
  - Consecutive targets are never equal across 20 rounds.
- Disable/reset mid-game: alarm_en=0 during SHOW -> IDLE, ringing=0, no dismissed pulse. rst=1 during ARM -> all outputs at reset values next cycle, fail_cnt=0.
- Saturation: force 260 mistakes -> fail_cnt holds at 255.
